// File: rtl/relm_div_pkg.sv
// Shared definitions for the relm_custom divide sequencer: FSM state codes,
// custom-unit sub-op encodings and a small state-decode helper.
package relm_div_pkg;

  // Sequencer states (kept as plain constants for legacy tool compatibility)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_INIT = 3'd1;
  localparam state_t ST_PRE  = 3'd2;
  localparam state_t ST_ITER = 3'd3;
  localparam state_t ST_FIN  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  // Sub-op codes carried in x[WOP+2:WOP] while OPB is set
  localparam logic [2:0] SUB_DIVINIT = 3'b100;
  localparam logic [2:0] SUB_DIVPRE  = 3'b010;
  localparam logic [2:0] SUB_DIVPREX = 3'b011;
  localparam logic [2:0] SUB_DIV     = 3'b000;
  localparam logic [2:0] SUB_DIVX    = 3'b001;

  // Low three opcode bits for every divide-family step
  localparam logic [2:0] OP_DIV = 3'b101;

  // True in the states that drive the custom unit
  function automatic logic is_active(input state_t st);
    logic act;
    case (st)
      ST_INIT, ST_PRE, ST_ITER, ST_FIN: act = 1'b1;
      default:                          act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/relm_div_seq_ctl.sv
// Control FSM and step counter of the divide sequencer. Publishes the current
// state plus the next state and next-cycle last-step flag so the top level
// can register its custom-unit control outputs one cycle ahead.
module relm_div_seq_ctl
  import relm_div_pkg::*;
#(
  parameter int PRE_STEPS  = 2,
  parameter int ITER_STEPS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       d_zero,
  input  logic       rsp_ready,
  input  logic       abort,
  output state_t     state,
  output state_t     state_nxt,
  output logic       last_nxt
);

  localparam int MAX_STEPS = (PRE_STEPS > ITER_STEPS) ? PRE_STEPS : ITER_STEPS;
  localparam int CW        = $clog2(MAX_STEPS) + 1;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next-state and counter logic; an abort overrides every step transition
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (abort && is_active(state_r)) begin
      state_s = ST_IDLE;
      cnt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            if (d_zero) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_INIT;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_INIT: begin
          state_s = ST_PRE;
          cnt_s   = CW'(PRE_STEPS - 1);
        end
        ST_PRE: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_s = ST_ITER;
            cnt_s   = CW'(ITER_STEPS - 1);
          end else begin
            cnt_s   = cnt_r - CW'(1);
          end
        end
        ST_ITER: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_s = ST_FIN;
          end else begin
            cnt_s   = cnt_r - CW'(1);
          end
        end
        ST_FIN: begin
          state_s = ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  assign state     = state_r;
  assign state_nxt = state_s;
  assign last_nxt  = (cnt_s == {CW{1'b0}});

endmodule

// File: rtl/relm_custom_div_seq.sv
// Divide-family sequencer for relm_custom: takes one unsigned N/D request,
// steps the combinational custom unit through DIVINIT, DIVPRE.., DIV.. and a
// final resolve, feeding a/cb results back each step.
// Optional build macro RELM_DIV_SEQ_ABORT_EN adds abort_in to cancel an
// in-flight sequence.
module relm_custom_div_seq
  import relm_div_pkg::*;
#(
  parameter int WD         = 32,
  parameter int WOP        = 5,
  parameter int WC         = 64,
  parameter int PRE_STEPS  = 2,
  parameter int ITER_STEPS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RELM_DIV_SEQ_ABORT_EN
  input  logic             abort_in,
`endif
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [WD-1:0]    n_in,
  input  logic [WD-1:0]    d_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [WD-1:0]    q_out,
  output logic             dz_out,
  output logic             retry_out,
  output logic [WOP-1:0]   cu_op_out,
  output logic             cu_opb_out,
  output logic [WD-1:0]    cu_x_out,
  output logic [WD-1:0]    cu_a_out,
  output logic [WC+WD-1:0] cu_cb_out,
  input  logic [WD-1:0]    cu_a_in,
  input  logic [WC+WD-1:0] cu_cb_in
);

  localparam logic [WOP-1:0] OP_FIELD = {{(WOP-3){1'b0}}, OP_DIV};

  state_t             state_s;
  state_t             state_nxt_s;
  logic               last_nxt_s;
  logic               abort_s;
  logic               abort_take_s;
  logic               d_zero_s;

  logic [WD-1:0]      a_r;
  logic [WC+WD-1:0]   cb_r;
  logic [WD-1:0]      s_r;
  logic [WD-1:0]      q_r;
  logic               dz_r;
  logic               req_ready_r;
  logic               rsp_valid_r;
  logic               retry_r;
  logic [WOP-1:0]     op_r;
  logic               opb_r;
  logic [WD-1:0]      x_r;

  logic [WOP-1:0]     op_nxt_s;
  logic               opb_nxt_s;
  logic [WD-1:0]      x_nxt_s;

`ifdef RELM_DIV_SEQ_ABORT_EN
  assign abort_s = abort_in;
`else
  assign abort_s = 1'b0;
`endif

  assign abort_take_s = abort_s && is_active(state_s);
  assign d_zero_s     = (d_in == {WD{1'b0}});

  relm_div_seq_ctl #(
    .PRE_STEPS  (PRE_STEPS),
    .ITER_STEPS (ITER_STEPS)
  ) u_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid_in),
    .d_zero    (d_zero_s),
    .rsp_ready (rsp_ready_in),
    .abort     (abort_s),
    .state     (state_s),
    .state_nxt (state_nxt_s),
    .last_nxt  (last_nxt_s)
  );

  // Place a sub-op code in its x field, all other bits zero
  function automatic logic [WD-1:0] sub_field(input logic [2:0] sub);
    logic [WD-1:0] f;
    f              = {WD{1'b0}};
    f[WOP+2:WOP]   = sub;
    return f;
  endfunction

  // Custom-unit control for the coming cycle, decoded from the next state
  always_comb begin
    op_nxt_s  = {WOP{1'b0}};
    opb_nxt_s = 1'b0;
    x_nxt_s   = {WD{1'b0}};
    case (state_nxt_s)
      ST_INIT: begin
        op_nxt_s  = OP_FIELD;
        opb_nxt_s = 1'b1;
        x_nxt_s   = sub_field(SUB_DIVINIT);
      end
      ST_PRE: begin
        op_nxt_s  = OP_FIELD;
        opb_nxt_s = 1'b1;
        if (last_nxt_s) begin
          x_nxt_s = sub_field(SUB_DIVPREX);
        end else begin
          x_nxt_s = sub_field(SUB_DIVPRE);
        end
      end
      ST_ITER: begin
        op_nxt_s  = OP_FIELD;
        opb_nxt_s = 1'b1;
        if (last_nxt_s) begin
          x_nxt_s = sub_field(SUB_DIVX);
        end else begin
          x_nxt_s = sub_field(SUB_DIV);
        end
      end
      ST_FIN: begin
        // Resolve step: x carries the full value captured at DIVINIT
        op_nxt_s  = OP_FIELD;
        opb_nxt_s = 1'b0;
        x_nxt_s   = s_r;
      end
      default: begin
        op_nxt_s  = {WOP{1'b0}};
        opb_nxt_s = 1'b0;
        x_nxt_s   = {WD{1'b0}};
      end
    endcase
  end

  // Operand/feedback registers and result capture; operands are zero
  // whenever no step is running so cu_a/cu_cb idle at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= {WD{1'b0}};
      cb_r <= {(WC+WD){1'b0}};
      s_r  <= {WD{1'b0}};
      q_r  <= {WD{1'b0}};
      dz_r <= 1'b0;
    end else if (abort_take_s) begin
      a_r  <= {WD{1'b0}};
      cb_r <= {(WC+WD){1'b0}};
      s_r  <= {WD{1'b0}};
    end else begin
      case (state_s)
        ST_IDLE: begin
          if (req_valid_in) begin
            if (d_zero_s) begin
              q_r  <= {WD{1'b1}};
              dz_r <= 1'b1;
            end else begin
              a_r  <= d_in;
              cb_r <= {{WC{1'b0}}, n_in};
            end
          end
        end
        ST_INIT: begin
          a_r  <= cu_a_in;
          s_r  <= cu_a_in;
          cb_r <= cu_cb_in;
        end
        ST_PRE, ST_ITER: begin
          a_r  <= cu_a_in;
          cb_r <= cu_cb_in;
        end
        ST_FIN: begin
          q_r  <= cu_a_in;
          dz_r <= 1'b0;
          a_r  <= {WD{1'b0}};
          cb_r <= {(WC+WD){1'b0}};
          s_r  <= {WD{1'b0}};
        end
        default: begin
          a_r  <= a_r;
        end
      endcase
    end
  end

  // Registered handshake, stall and custom-unit control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      retry_r     <= 1'b0;
      op_r        <= {WOP{1'b0}};
      opb_r       <= 1'b0;
      x_r         <= {WD{1'b0}};
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_DONE);
      retry_r     <= (state_nxt_s != ST_IDLE);
      op_r        <= op_nxt_s;
      opb_r       <= opb_nxt_s;
      x_r         <= x_nxt_s;
    end
  end

  assign req_ready_out = req_ready_r;
  assign rsp_valid_out = rsp_valid_r;
  assign retry_out     = retry_r;
  assign q_out         = q_r;
  assign dz_out        = dz_r;
  assign cu_op_out     = op_r;
  assign cu_opb_out    = opb_r;
  assign cu_x_out      = x_r;
  assign cu_a_out      = a_r;
  assign cu_cb_out     = cb_r;

endmodule
